serial_addsub: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Successor to the single-bit full adder.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB chunk first, through one DIGIT-bit ripple slice.
- Carry is held in a register between cycles.
- Start/busy/done handshake. Add or subtract selected per operation. Reports carry-out and signed overflow.

---
 rtl/serial_addsub.sv | 162 ++++++++++++++++
 tb/tb_serial_addsub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor.
// Each WIDTH-bit operation is processed DIGIT bits per clock, starting
// with the least-significant chunk. A single DIGIT-bit ripple slice does
// the work, and a register carries the carry from one chunk to the next.
//
// Ports
//   clk    : clock; all state changes on the rising edge
//   rst_n  : synchronous reset, active low
//   start  : operation request; ignored while busy
//   sub    : 0 = a + b + c_in, 1 = a - b - c_in (sampled with start)
//   a, b   : operands (sampled with start)
//   c_in   : carry-in for add, borrow-in for subtract (sampled with start)
//   busy   : an operation is in progress
//   done   : one-cycle pulse; sum/c_out/ovf were updated on this edge
//   sum    : result; holds until the next completion
//   c_out  : carry-out for add; for subtract, 1 = no borrow
//   ovf    : two's-complement overflow of the result
//
// state  | meaning
// S_IDLE | waiting for start; outputs hold the last result
// S_RUN  | one chunk per edge; counter selects the last chunk
// S_DONE | result presented for one cycle; start is accepted here too
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT:0]       chunk;
    logic [WIDTH+DIGIT-1:0] res_shift;
    logic                 msb_cin;

    always_comb begin
        chunk     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        // New chunk enters at the top; after STEPS shifts the result is aligned.
        res_shift = {chunk[DIGIT-1:0], res_q};
        // Carry into the chunk MSB recovered from its sum bit and operand bits.
        msb_cin   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ chunk[DIGIT-1];

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    // Subtract as a + ~b + ~c_in so the same slice serves both modes.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = c_in ^ sub;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chunk[DIGIT];
                res_d   = res_shift[WIDTH+DIGIT-1:DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    sum_d   = res_shift[WIDTH+DIGIT-1:DIGIT];
                    c_out_d = chunk[DIGIT];
                    ovf_d   = msb_cin ^ chunk[DIGIT];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three WIDTH=8 instances with DIGIT = 1, 4, 8.
// Stimulus pushes expected results into per-instance queues; a monitor per
// instance checks done latency, results, held outputs and busy every cycle.
module tb_serial_addsub;

    localparam int NI = 3;

    typedef struct {
        int         acc;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [NI];
    logic       sub   [NI];
    logic       c_in  [NI];
    logic [7:0] a     [NI];
    logic [7:0] b     [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic [7:0] sum   [NI];
    logic       c_out [NI];
    logic       ovf   [NI];

    exp_t       exp_q [NI][$];
    int         last_acc [NI];
    logic [7:0] hold_s  [NI];
    logic       hold_co [NI];
    logic       hold_ov [NI];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int steps_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 1;
    endfunction

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic s, input logic ci, input int acc);
        exp_t e;
        int   full;
        int   sres;
        if (!s) begin
            full = int'(x) + int'(y) + int'(ci);
            sres = int'($signed(x)) + int'($signed(y)) + int'(ci);
            e.co = (full > 255);
        end else begin
            full = int'(x) - int'(y) - int'(ci);
            sres = int'($signed(x)) - int'($signed(y)) - int'(ci);
            e.co = (full >= 0);
        end
        e.s   = full[7:0];
        e.ov  = (sres > 127) || (sres < -128);
        e.acc = acc;
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic monitor(input int i);
        exp_t e;
        logic bexp;
        if (done[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
                chk("spurious_done", i, 32'(done[i]), 32'd0);
            end else begin
                e = exp_q[i].pop_front();
                chk("latency", i, 32'(cyc - e.acc), 32'(steps_of(i)));
                hold_s[i]  = e.s;
                hold_co[i] = e.co;
                hold_ov[i] = e.ov;
            end
        end else if (exp_q[i].size() > 0 && cyc > exp_q[i][0].acc + steps_of(i)) begin
            chk("done_timeout", i, 32'(done[i]), 32'd1);
            void'(exp_q[i].pop_front());
        end
        bexp = (last_acc[i] >= 0) && (cyc >= last_acc[i]) &&
               (cyc < last_acc[i] + steps_of(i));
        chk("busy",  i, 32'(busy[i]),  32'(bexp));
        chk("sum",   i, 32'(sum[i]),   32'(hold_s[i]));
        chk("c_out", i, 32'(c_out[i]), 32'(hold_co[i]));
        chk("ovf",   i, 32'(ovf[i]),   32'(hold_ov[i]));
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        serial_addsub #(
            .WIDTH(8),
            .DIGIT((gi == 0) ? 1 : (gi == 1) ? 4 : 8)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start[gi]),
            .sub   (sub[gi]),
            .a     (a[gi]),
            .b     (b[gi]),
            .c_in  (c_in[gi]),
            .busy  (busy[gi]),
            .done  (done[gi]),
            .sum   (sum[gi]),
            .c_out (c_out[gi]),
            .ovf   (ovf[gi])
        );
        always @(negedge clk) if (mon_en) monitor(gi);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Called just after an edge while instance i is idle or in its done cycle.
    // Returns just after the completion edge (the done cycle).
    task automatic do_op(input int i, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input logic ci);
        a[i] = x; b[i] = y; sub[i] = s; c_in[i] = ci; start[i] = 1'b1;
        tick();
        exp_q[i].push_back(model(x, y, s, ci, cyc));
        last_acc[i] = cyc;
        start[i] = 1'b0;
        a[i] = 8'($urandom); b[i] = 8'($urandom);
        sub[i] = 1'($urandom); c_in[i] = 1'($urandom);
        idle(steps_of(i));
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            last_acc[i] = -1;
            hold_s[i]   = 8'h00;
            hold_co[i]  = 1'b0;
            hold_ov[i]  = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] x, y;
        logic       s, ci;
        logic [3:0] vb;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; sub[i] = 1'b0; c_in[i] = 1'b0;
            a[i] = 8'h00; b[i] = 8'h00;
        end
        clear_model();
        idle(3);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Directed vectors, chained back to back on the DIGIT=1 instance.
        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b1);
        do_op(0, 8'h10, 8'h20, 1'b1, 1'b0);
        do_op(0, 8'h80, 8'h01, 1'b1, 1'b0);
        do_op(0, 8'h05, 8'h05, 1'b1, 1'b1);
        idle(3);

        // start held through RUN with operands churning; second op taken in done cycle.
        a[0] = 8'h37; b[0] = 8'hC9; sub[0] = 1'b0; c_in[0] = 1'b1; start[0] = 1'b1;
        tick();
        exp_q[0].push_back(model(8'h37, 8'hC9, 1'b0, 1'b1, cyc));
        last_acc[0] = cyc;
        for (int k = 0; k < steps_of(0); k++) begin
            a[0] = 8'($urandom); b[0] = 8'($urandom);
            sub[0] = 1'($urandom); c_in[0] = 1'($urandom);
            tick();
        end
        a[0] = 8'hA4; b[0] = 8'h5B; sub[0] = 1'b1; c_in[0] = 1'b0;
        tick();
        exp_q[0].push_back(model(8'hA4, 8'h5B, 1'b1, 1'b0, cyc));
        last_acc[0] = cyc;
        start[0] = 1'b0;
        idle(steps_of(0) + 2);

        // Corner operands {00, FF} in both modes on every instance.
        for (int i = 0; i < NI; i++) begin
            for (int v = 0; v < 16; v++) begin
                vb = v[3:0];
                do_op(i, vb[0] ? 8'hFF : 8'h00, vb[1] ? 8'hFF : 8'h00, vb[3], vb[2]);
            end
            idle(2);
        end

        // Random operations with random idle gaps (0 keeps ops back to back).
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 30; n++) begin
                x = 8'($urandom); y = 8'($urandom);
                s = 1'($urandom); ci = 1'($urandom);
                do_op(i, x, y, s, ci);
                idle($urandom_range(0, 2));
            end
            idle(2);
        end

        // Reset asserted at the 4th RUN edge aborts the op; no done may follow.
        a[0] = 8'h7E; b[0] = 8'h19; sub[0] = 1'b0; c_in[0] = 1'b0; start[0] = 1'b1;
        tick();
        exp_q[0].push_back(model(8'h7E, 8'h19, 1'b0, 1'b0, cyc));
        last_acc[0] = cyc;
        start[0] = 1'b0;
        idle(3);
        rst_n = 1'b0;
        tick();
        clear_model();
        rst_n = 1'b1;
        idle(12);

        for (int i = 0; i < NI; i++)
            chk("pending_at_end", i, 32'(exp_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
